// File: rtl/ftdi_tx_arbiter_if.sv
// Requester-side and FT232H-side stream bundle for ftdi_tx_arbiter.
// slave = arbiter side, master = the environment driving it.
interface ftdi_tx_arbiter_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]   ch_en;
    logic [8*NUM_CH-1:0] s_tdata;
    logic [NUM_CH-1:0]   s_tvalid;
    logic [NUM_CH-1:0]   s_tlast;
    logic [NUM_CH-1:0]   s_tready;
    logic [7:0]          m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic [3:0]          grant;
    logic                busy;

    modport slave (
        input  ch_en, s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, grant, busy
    );

    modport master (
        output ch_en, s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, grant, busy
    );
endinterface

// File: rtl/ftdi_tx_arbiter.sv
// Round-robin framing arbiter feeding the FT232H transmit byte stream.
// Define FTDI_ARB_CHECKSUM_EN to append an XOR checksum trailer per packet.
module ftdi_tx_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int MAX_PKT_LEN = 64
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    ftdi_tx_arbiter_if.slave bus
);
    localparam int LW = $clog2(MAX_PKT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef FTDI_ARB_CHECKSUM_EN
        TRAILER = 2'd2,
`endif
        PAYLOAD = 2'd1
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic [3:0]        grant_q, grant_d;
    logic [3:0]        last_grant_q, last_grant_d;
    logic [NUM_CH-1:0] cont_q, cont_d;
    logic [LW-1:0]     len_q, len_d;
`ifdef FTDI_ARB_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              slot_free;
    logic              found;
    logic [3:0]        win;
    logic              win_cont;
    logic [7:0]        hdr;
    logic              g_valid;
    logic              g_last;
    logic [7:0]        g_data;
    logic              accept;
    logic [LW-1:0]     len_inc;
    logic              at_limit;

    assign slot_free = ~m_tvalid_q | bus.m_tready;
    assign len_inc   = len_q + 1'b1;
    assign at_limit  = (len_inc == LW'(MAX_PKT_LEN));
    assign accept    = (state_q == PAYLOAD) & slot_free & g_valid;
    assign hdr       = {1'b1, win_cont, 2'b00, win};

    // Granted-channel mux, written with constant indices only.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q == 4'(i)) begin
                g_valid = bus.s_tvalid[i];
                g_last  = bus.s_tlast[i];
                g_data  = bus.s_tdata[8*i +: 8];
            end
        end
    end

    // Winner is the candidate at the smallest distance past last_grant.
    always_comb begin
        int d;
        int best_d;
        found    = 1'b0;
        win      = grant_q;
        win_cont = 1'b0;
        best_d   = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            d = (i + NUM_CH - int'(last_grant_q) - 1) % NUM_CH;
            if (bus.s_tvalid[i] && bus.ch_en[i] && d < best_d) begin
                found    = 1'b1;
                best_d   = d;
                win      = 4'(i);
                win_cont = cont_q[i];
            end
        end
    end

    always_comb begin
        bus.s_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.s_tready[i] = (state_q == PAYLOAD) && slot_free &&
                              (grant_q == 4'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cont_d       = cont_q;
        len_d        = len_q;
`ifdef FTDI_ARB_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (slot_free) begin
            m_tvalid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (slot_free && found) begin
                    grant_d      = win;
                    last_grant_d = win;
                    m_tdata_d    = hdr;
                    m_tvalid_d   = 1'b1;
                    len_d        = '0;
`ifdef FTDI_ARB_CHECKSUM_EN
                    csum_d       = hdr;
`endif
                    state_d      = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    m_tdata_d  = g_data;
                    m_tvalid_d = 1'b1;
                    len_d      = len_inc;
`ifdef FTDI_ARB_CHECKSUM_EN
                    csum_d     = csum_q ^ g_data;
`endif
                    if (g_last || at_limit) begin
`ifdef FTDI_ARB_CHECKSUM_EN
                        state_d = TRAILER;
`else
                        state_d = IDLE;
`endif
                        // A limit hit without tlast marks the next header.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (grant_q == 4'(i)) begin
                                cont_d[i] = ~g_last;
                            end
                        end
                    end
                end
            end
`ifdef FTDI_ARB_CHECKSUM_EN
            TRAILER: begin
                if (slot_free) begin
                    m_tdata_d  = csum_q;
                    m_tvalid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            m_tdata_q    <= 8'h00;
            m_tvalid_q   <= 1'b0;
            grant_q      <= 4'd0;
            last_grant_q <= 4'(NUM_CH - 1);
            cont_q       <= '0;
            len_q        <= '0;
`ifdef FTDI_ARB_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cont_q       <= cont_d;
            len_q        <= len_d;
`ifdef FTDI_ARB_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign bus.m_tdata  = m_tdata_q;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Directed bench for ftdi_tx_arbiter: cycle table plus stream sequences.
// Expectations follow FTDI_ARB_CHECKSUM_EN when it is defined.
module tb_ftdi_tx_arbiter;
    localparam int NCH = 4;
    localparam int MPL = 4;
`ifdef FTDI_ARB_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ftdi_tx_arbiter_if #(.NUM_CH(NCH)) bus();

    ftdi_tx_arbiter #(.NUM_CH(NCH), .MAX_PKT_LEN(MPL)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [3:0] vld;
        logic [3:0] lst;
        logic [7:0] dat;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] esr;
    } vec_t;

    vec_t vec [13];

    int checks = 0;
    int failures = 0;

    logic [8:0] srcq [NCH][$];
    logic [7:0] outq [$];
    logic [7:0] expq [$];
    logic [7:0] run_cs;
    bit         sr1_seen;
    logic       smp_v;
    logic [7:0] smp_d;
    logic [3:0] smp_sr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(logic [3:0] vld, logic [3:0] lst,
                                logic [7:0] dat, logic rdy, logic ev,
                                logic [7:0] ed, logic [3:0] esr);
        vec_t v;
        v.vld = vld; v.lst = lst; v.dat = dat; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.esr = esr;
        return v;
    endfunction

    task automatic drive_q();
        for (int i = 0; i < NCH; i++) begin
            if (srcq[i].size() > 0) begin
                bus.s_tvalid[i]       = 1'b1;
                bus.s_tdata[8*i +: 8] = srcq[i][0][7:0];
                bus.s_tlast[i]        = srcq[i][0][8];
            end else begin
                bus.s_tvalid[i]       = 1'b0;
                bus.s_tdata[8*i +: 8] = 8'h00;
                bus.s_tlast[i]        = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        smp_v  = bus.m_tvalid;
        smp_d  = bus.m_tdata;
        smp_sr = bus.s_tready;
        if (bus.s_tready[1]) sr1_seen = 1'b1;
        if (bus.m_tvalid && bus.m_tready) outq.push_back(bus.m_tdata);
        for (int i = 0; i < NCH; i++) begin
            if (bus.s_tvalid[i] && bus.s_tready[i]) begin
                void'(srcq[i].pop_front());
            end
        end
        @(posedge clk);
        #1;
        drive_q();
    endtask

    task automatic src(int ch, logic [7:0] b, logic last);
        srcq[ch].push_back({last, b});
    endtask

    task automatic exp_hdr(logic [7:0] h);
        expq.push_back(h);
        run_cs = h;
    endtask

    task automatic exp_byte(logic [7:0] b);
        expq.push_back(b);
        run_cs = run_cs ^ b;
    endtask

    task automatic exp_end();
        if (CS) expq.push_back(run_cs);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NCH; i++) srcq[i].delete();
        outq.delete();
        expq.delete();
    endtask

    task automatic run_until(string nm, int n, int tail);
        int cyc = 0;
        while (outq.size() < n && cyc < 300) begin
            step();
            cyc++;
        end
        chk({nm, "_in_time"}, 32'(cyc < 300), 32'd1);
        repeat (tail) step();
    endtask

    task automatic compare(string nm);
        chk({nm, "_len"}, outq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            chk($sformatf("%s[%0d]", nm, i),
                (i < outq.size()) ? 32'(outq[i]) : 32'hdead,
                32'(expq[i]));
        end
    endtask

    task automatic do_reset(bit check);
        rst_n = 1'b0;
        clear_all();
        bus.m_tready = 1'b1;
        bus.ch_en    = '1;
        drive_q();
        @(negedge clk);
        if (check) begin
            chk("rst_m_tvalid", bus.m_tvalid, 0);
            chk("rst_m_tdata", bus.m_tdata, 0);
            chk("rst_s_tready", bus.s_tready, 0);
            chk("rst_grant", bus.grant, 0);
            chk("rst_busy", bus.busy, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] held;

        vec[0]  = mk(4'h1, 4'h0, 8'h11, 1, 0, 8'h00, 4'h0);
        vec[1]  = mk(4'h1, 4'h0, 8'h11, 1, 1, 8'h80, 4'h1);
        vec[2]  = mk(4'h1, 4'h0, 8'h22, 1, 1, 8'h11, 4'h1);
        vec[3]  = mk(4'h1, 4'h1, 8'h33, 1, 1, 8'h22, 4'h1);
        vec[4]  = mk(4'h0, 4'h0, 8'h00, 1, 1, 8'h33, 4'h0);
        vec[5]  = mk(4'h0, 4'h0, 8'h00, 1, CS, 8'h80, 4'h0);
        vec[6]  = mk(4'h0, 4'h0, 8'h00, 1, 0, 8'h00, 4'h0);
        vec[7]  = mk(4'h1, 4'h0, 8'h44, 0, 0, 8'h00, 4'h0);
        vec[8]  = mk(4'h1, 4'h0, 8'h44, 0, 1, 8'h80, 4'h0);
        vec[9]  = mk(4'h1, 4'h1, 8'h44, 1, 1, 8'h80, 4'h1);
        vec[10] = mk(4'h0, 4'h0, 8'h00, 1, 1, 8'h44, 4'h0);
        vec[11] = mk(4'h0, 4'h0, 8'h00, 1, CS, 8'hC4, 4'h0);
        vec[12] = mk(4'h0, 4'h0, 8'h00, 1, 0, 8'h00, 4'h0);

        do_reset(1'b1);

        for (int r = 0; r < 13; r++) begin
            bus.s_tvalid = vec[r].vld;
            bus.s_tlast  = vec[r].lst;
            bus.s_tdata  = {NCH{vec[r].dat}};
            bus.m_tready = vec[r].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_m_tvalid", r), bus.m_tvalid, vec[r].ev);
            if (vec[r].ev) begin
                chk($sformatf("tbl%0d_m_tdata", r), bus.m_tdata, vec[r].ed);
            end
            chk($sformatf("tbl%0d_s_tready", r), bus.s_tready, vec[r].esr);
            @(posedge clk);
            #1;
        end

        // Fairness: every channel holds two 1-byte packets.
        do_reset(1'b0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NCH; c++) begin
                src(c, 8'(8'h10 + r * 4 + c), 1'b1);
                exp_hdr(8'(8'h80 + c));
                exp_byte(8'(8'h10 + r * 4 + c));
                exp_end();
            end
        end
        drive_q();
        run_until("fair", expq.size(), 3);
        compare("fair");

        // Forced split on ch2, exact-limit tlast on ch1.
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) src(1, 8'(8'h50 + k), 1'(k == 3));
        src(1, 8'h54, 1'b1);
        for (int k = 0; k < 6; k++) src(2, 8'(8'hA0 + k), 1'(k == 5));
        src(2, 8'hB0, 1'b1);
        exp_hdr(8'h81);
        for (int k = 0; k < 4; k++) exp_byte(8'(8'h50 + k));
        exp_end();
        exp_hdr(8'h82);
        for (int k = 0; k < 4; k++) exp_byte(8'(8'hA0 + k));
        exp_end();
        exp_hdr(8'h81); exp_byte(8'h54); exp_end();
        exp_hdr(8'hC2); exp_byte(8'hA4); exp_byte(8'hA5); exp_end();
        exp_hdr(8'h82); exp_byte(8'hB0); exp_end();
        drive_q();
        run_until("split", expq.size(), 3);
        compare("split");

        // Enable mask keeps ch1 out of arbitration.
        do_reset(1'b0);
        bus.ch_en = 4'b1101;
        sr1_seen  = 1'b0;
        src(0, 8'hD0, 1'b1); src(0, 8'hD1, 1'b1);
        src(1, 8'hE0, 1'b1); src(1, 8'hE1, 1'b1);
        src(2, 8'hF0, 1'b1); src(2, 8'hF1, 1'b1);
        exp_hdr(8'h80); exp_byte(8'hD0); exp_end();
        exp_hdr(8'h82); exp_byte(8'hF0); exp_end();
        exp_hdr(8'h80); exp_byte(8'hD1); exp_end();
        exp_hdr(8'h82); exp_byte(8'hF1); exp_end();
        drive_q();
        run_until("mask", expq.size(), 3);
        compare("mask");
        chk("mask_sr1_seen", 32'(sr1_seen), 0);
        chk("mask_ch1_left", srcq[1].size(), 2);
        chk("mask_grant_hold", bus.grant, 2);
        chk("mask_busy_idle", bus.busy, 0);

        // Backpressure for five cycles mid-payload.
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) src(0, 8'(8'h01 + k), 1'(k == 3));
        exp_hdr(8'h80);
        for (int k = 0; k < 4; k++) exp_byte(8'(8'h01 + k));
        exp_end();
        drive_q();
        run_until("bp_pre", 2, 0);
        held = expq[2];
        bus.m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("bp%0d_m_tvalid", k), smp_v, 1);
            chk($sformatf("bp%0d_m_tdata", k), smp_d, held);
            chk($sformatf("bp%0d_s_tready", k), smp_sr, 0);
        end
        bus.m_tready = 1'b1;
        run_until("bp", expq.size(), 3);
        compare("bp");

        // Asynchronous reset in the middle of a ch1 payload.
        do_reset(1'b0);
        src(1, 8'h31, 1'b0); src(1, 8'h32, 1'b0); src(1, 8'h33, 1'b1);
        drive_q();
        run_until("rmid_pre", 2, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_m_tvalid", bus.m_tvalid, 0);
        chk("rmid_busy", bus.busy, 0);
        clear_all();
        src(3, 8'h73, 1'b1);
        src(0, 8'h70, 1'b1);
        exp_hdr(8'h80); exp_byte(8'h70); exp_end();
        exp_hdr(8'h83); exp_byte(8'h73); exp_end();
        drive_q();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_until("rmid", expq.size(), 3);
        compare("rmid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
